// File: rtl/sprite_pkg.sv
// Shared constants for the sprite/VGA path: key and fill colours, player sprite
// dimensions and screen geometry.
package sprite_pkg;

    localparam logic [7:0] TRANSPARENT_COLOR = 8'hE3;
    localparam logic [7:0] BG_COLOR_DEF      = 8'h00;
    localparam logic [7:0] COUNTDOWN_COLOR   = 8'hFC;

    localparam int PLAYER_W = 113;
    localparam int PLAYER_H = 157;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/sprite_addr_gen.sv
// One sprite channel's stage A: inside test, horizontal mirror and registered
// ROM address (0 whenever the pixel is outside the sprite).
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W   = PLAYER_W,
    parameter int SPR_H   = PLAYER_H,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_mirror,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_spr_x,
    input  logic [COORD_W-1:0] i_spr_y,
    output logic               o_inside,
    output logic [ADDR_W-1:0]  o_addr
);

    localparam int CW1 = COORD_W + 1;
    localparam logic [CW1-1:0]     SPR_W_C  = CW1'(SPR_W);
    localparam logic [CW1-1:0]     SPR_H_C  = CW1'(SPR_H);
    localparam logic [COORD_W-1:0] SPR_W_M1 = COORD_W'(SPR_W - 1);
    localparam logic [ADDR_W-1:0]  SPR_W_A  = ADDR_W'(SPR_W);

    logic [CW1-1:0]     w_x, w_y, w_x_lo, w_y_lo, w_x_hi, w_y_hi;
    logic               w_inside;
    logic [COORD_W-1:0] w_rel_x, w_rel_y, w_col;
    logic [ADDR_W-1:0]  w_addr;
    logic               r_inside;
    logic [ADDR_W-1:0]  r_addr;

    // One extra bit keeps sprites hanging off the right/bottom edge from wrapping.
    assign w_x    = {1'b0, i_x};
    assign w_y    = {1'b0, i_y};
    assign w_x_lo = {1'b0, i_spr_x};
    assign w_y_lo = {1'b0, i_spr_y};
    assign w_x_hi = w_x_lo + SPR_W_C;
    assign w_y_hi = w_y_lo + SPR_H_C;

    assign w_inside = i_en && (w_x >= w_x_lo) && (w_x < w_x_hi)
                           && (w_y >= w_y_lo) && (w_y < w_y_hi);

    assign w_rel_x = i_x - i_spr_x;
    assign w_rel_y = i_y - i_spr_y;
    assign w_col   = i_mirror ? (SPR_W_M1 - w_rel_x) : w_rel_x;
    assign w_addr  = ADDR_W'(w_rel_y) * SPR_W_A + ADDR_W'(w_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inside <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_inside <= w_inside;
            r_addr   <= w_inside ? w_addr : '0;
        end
    end

    assign o_inside = r_inside;
    assign o_addr   = r_addr;

endmodule

// File: rtl/sprite_compositor.sv
// Pipelined multi-channel sprite compositor: per-channel ROM addressing, ROM
// latency alignment, priority/transparency resolve and per-frame 0/1 collision.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int               NUM_SPRITES = 2,
    parameter int               SPR_W       = PLAYER_W,
    parameter int               SPR_H       = PLAYER_H,
    parameter int               COORD_W     = 10,
    parameter int               ADDR_W      = 15,
    parameter int               PIX_W       = 8,
    parameter int               ROM_LAT     = 1,
    parameter logic [PIX_W-1:0] TRANSPARENT = PIX_W'(TRANSPARENT_COLOR),
    parameter logic [PIX_W-1:0] BG_COLOR    = PIX_W'(BG_COLOR_DEF)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pix_valid_i,
    input  logic [COORD_W-1:0]             pix_x_i,
    input  logic [COORD_W-1:0]             pix_y_i,
    input  logic                           frame_start_i,
    input  logic [NUM_SPRITES-1:0]         spr_en_i,
    input  logic [NUM_SPRITES-1:0]         spr_mirror_i,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x_i,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y_i,
    output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr_o,
    input  logic [NUM_SPRITES*PIX_W-1:0]   rom_data_i,
    output logic                           pix_valid_o,
    output logic [PIX_W-1:0]               pix_data_o,
    output logic [NUM_SPRITES-1:0]         pix_sel_o,
    output logic                           collide_o,
    output logic                           collide_valid_o
);

    logic [NUM_SPRITES-1:0]                w_inside_a;
    logic [NUM_SPRITES-1:0][ADDR_W-1:0]    w_addr_a;
    logic [ROM_LAT:0]                      r_vld_pipe, r_fs_pipe;
    logic [ROM_LAT-1:0][NUM_SPRITES-1:0]   r_in_dl;
    logic [NUM_SPRITES-1:0]                w_opaque;
    logic [PIX_W-1:0]                      w_win_data;
    logic [NUM_SPRITES-1:0]                w_win_sel;
    logic                                  w_vld_c, w_fs_c, w_hit;

    logic                                  r_pix_valid;
    logic [PIX_W-1:0]                      r_pix_data;
    logic [NUM_SPRITES-1:0]                r_pix_sel;
    logic                                  r_collide, r_col_vld, r_acc, r_armed;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_chan
        sprite_addr_gen #(
            .SPR_W   (SPR_W),
            .SPR_H   (SPR_H),
            .COORD_W (COORD_W),
            .ADDR_W  (ADDR_W)
        ) u_addr_gen (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (spr_en_i[g]),
            .i_mirror (spr_mirror_i[g]),
            .i_x      (pix_x_i),
            .i_y      (pix_y_i),
            .i_spr_x  (spr_x_i[g*COORD_W +: COORD_W]),
            .i_spr_y  (spr_y_i[g*COORD_W +: COORD_W]),
            .o_inside (w_inside_a[g]),
            .o_addr   (w_addr_a[g])
        );

        assign w_opaque[g] = r_in_dl[ROM_LAT-1][g]
                          && (rom_data_i[g*PIX_W +: PIX_W] != TRANSPARENT);
    end

    assign rom_addr_o = w_addr_a;

    // Stage A tags plus ROM_LAT alignment stages; the top entry lines up with rom_data_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_fs_pipe  <= '0;
            r_in_dl    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[ROM_LAT-1:0], pix_valid_i};
            r_fs_pipe  <= {r_fs_pipe[ROM_LAT-1:0], pix_valid_i & frame_start_i};
            r_in_dl[0] <= w_inside_a;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_in_dl[i] <= r_in_dl[i-1];
            end
        end
    end

    assign w_vld_c = r_vld_pipe[ROM_LAT];
    assign w_fs_c  = r_fs_pipe[ROM_LAT];
    assign w_hit   = w_vld_c & w_opaque[0] & w_opaque[1];

    // Walk high to low so the lowest-index opaque channel is the last writer.
    always_comb begin
        w_win_data = BG_COLOR;
        w_win_sel  = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (w_opaque[k]) begin
                w_win_data = rom_data_i[k*PIX_W +: PIX_W];
                w_win_sel  = NUM_SPRITES'(1) << k;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_valid <= 1'b0;
            r_pix_data  <= BG_COLOR;
            r_pix_sel   <= '0;
        end else begin
            r_pix_valid <= w_vld_c;
            r_pix_data  <= w_vld_c ? w_win_data : BG_COLOR;
            r_pix_sel   <= w_vld_c ? w_win_sel : '0;
        end
    end

    // r_armed suppresses the report for a frame that was only partly seen after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collide <= 1'b0;
            r_col_vld <= 1'b0;
            r_acc     <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_col_vld <= 1'b0;
            if (w_fs_c) begin
                if (r_armed) begin
                    r_collide <= r_acc;
                    r_col_vld <= 1'b1;
                end
                r_armed <= 1'b1;
                r_acc   <= w_hit;
            end else if (w_hit) begin
                r_acc <= 1'b1;
            end
        end
    end

    assign pix_valid_o     = r_pix_valid;
    assign pix_data_o      = r_pix_data;
    assign pix_sel_o       = r_pix_sel;
    assign collide_o       = r_collide;
    assign collide_valid_o = r_col_vld;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus random
// traffic checked against a coordinate-level reference model.
module tb_sprite_compositor;

    localparam int CW = 10;
    localparam int AW = 15;
    localparam int SW = 113;
    localparam int SH = 157;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pix_valid_i, frame_start_i;
    logic [CW-1:0] pix_x_i, pix_y_i;
    logic [1:0]    spr_en_i, spr_mirror_i;
    logic [2*CW-1:0] spr_x_i, spr_y_i;

    logic [2*AW-1:0] rom_addr1, rom_addr2;
    logic [15:0]     rom_data1, rom_data2;
    logic            pv1, pv2, col1, col2, cv1, cv2;
    logic [7:0]      pd1, pd2;
    logic [1:0]      ps1, ps2;

    always #5 clk = ~clk;

    sprite_compositor u_dut (
        .clk(clk), .rst_n(rst_n), .pix_valid_i(pix_valid_i), .pix_x_i(pix_x_i),
        .pix_y_i(pix_y_i), .frame_start_i(frame_start_i), .spr_en_i(spr_en_i),
        .spr_mirror_i(spr_mirror_i), .spr_x_i(spr_x_i), .spr_y_i(spr_y_i),
        .rom_addr_o(rom_addr1), .rom_data_i(rom_data1), .pix_valid_o(pv1),
        .pix_data_o(pd1), .pix_sel_o(ps1), .collide_o(col1), .collide_valid_o(cv1)
    );

    sprite_compositor #(.ROM_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pix_valid_i(pix_valid_i), .pix_x_i(pix_x_i),
        .pix_y_i(pix_y_i), .frame_start_i(frame_start_i), .spr_en_i(spr_en_i),
        .spr_mirror_i(spr_mirror_i), .spr_x_i(spr_x_i), .spr_y_i(spr_y_i),
        .rom_addr_o(rom_addr2), .rom_data_i(rom_data2), .pix_valid_o(pv2),
        .pix_data_o(pd2), .pix_sel_o(ps2), .collide_o(col2), .collide_valid_o(cv2)
    );

    // ROM contents: constant per channel, or an address hash with some keyed pixels.
    int         rom_mode;
    logic [7:0] rom_const [2];

    function automatic logic [7:0] rom_f(input int k, input int a);
        if (rom_mode == 0) return rom_const[k];
        if ((a % 7) == k) return 8'hE3;
        return 8'((a * 37 + k * 101 + (a >> 4)) & 255);
    endfunction

    logic [7:0] rq1 [2];
    logic [7:0] rs2 [2];
    logic [7:0] rq2 [2];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rq1[k] <= rom_f(k, int'(rom_addr1[k*AW +: AW]));
            rs2[k] <= rom_f(k, int'(rom_addr2[k*AW +: AW]));
            rq2[k] <= rs2[k];
        end
    end
    assign rom_data1 = {rq1[1], rq1[0]};
    assign rom_data2 = {rq2[1], rq2[0]};

    // Expected outputs indexed by the cycle on which they must be observed.
    logic        exp_pv  [DEPTH];
    logic [7:0]  exp_pd  [DEPTH];
    logic [1:0]  exp_ps  [DEPTH];
    logic        exp_col [DEPTH];
    logic        exp_cv  [DEPTH];
    logic [14:0] exp_a0  [DEPTH];
    logic [14:0] exp_a1  [DEPTH];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int sx [2], sy [2];
    bit en [2], mir [2];
    bit m_armed, m_acc, m_col;

    task automatic clear_exp(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            exp_pv[i] = 0; exp_pd[i] = 8'h00; exp_ps[i] = 0;
            exp_col[i] = 0; exp_cv[i] = 0; exp_a0[i] = 0; exp_a1[i] = 0;
        end
    endtask

    task automatic set_spr(input int k, input bit e, input bit m, input int x, input int y);
        en[k] = e; mir[k] = m; sx[k] = x; sy[k] = y;
        spr_en_i[k] = e; spr_mirror_i[k] = m;
        spr_x_i[k*CW +: CW] = CW'(x);
        spr_y_i[k*CW +: CW] = CW'(y);
    endtask

    task automatic drive(input bit v, input int x, input int y, input bit fs);
        bit ins [2];
        bit opq [2];
        int addr [2];
        logic [7:0] d;
        bit hit, cv;
        pix_valid_i = v; pix_x_i = CW'(x); pix_y_i = CW'(y); frame_start_i = fs;
        for (int k = 0; k < 2; k++) begin
            ins[k] = en[k] && x >= sx[k] && x < sx[k] + SW && y >= sy[k] && y < sy[k] + SH;
            addr[k] = ins[k] ? ((y - sy[k]) * SW + (mir[k] ? SW - 1 - (x - sx[k]) : x - sx[k])) % 32768 : 0;
            opq[k] = ins[k] && rom_f(k, addr[k]) != 8'hE3;
        end
        exp_a0[cyc+1] = 15'(addr[0]);
        exp_a1[cyc+1] = 15'(addr[1]);
        exp_pv[cyc+3] = v;
        exp_pd[cyc+3] = 8'h00;
        exp_ps[cyc+3] = 2'b00;
        if (v && opq[0]) begin
            d = rom_f(0, addr[0]); exp_pd[cyc+3] = d; exp_ps[cyc+3] = 2'b01;
        end else if (v && opq[1]) begin
            d = rom_f(1, addr[1]); exp_pd[cyc+3] = d; exp_ps[cyc+3] = 2'b10;
        end
        hit = v && opq[0] && opq[1];
        cv = 0;
        if (v && fs) begin
            if (m_armed) begin m_col = m_acc; cv = 1; end
            m_armed = 1; m_acc = hit;
        end else if (hit) begin
            m_acc = 1;
        end
        exp_cv[cyc+3] = cv;
        exp_col[cyc+3] = m_col;
    endtask

    task automatic step(input bit v, input int x, input int y, input bit fs);
        drive(v, x, y, fs);
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        n_chk++; if (pv1 !== 1'b0 || pv2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b/%b want 0", pv1, pv2); end
        n_chk++; if (pd1 !== 8'h00 || ps1 !== 2'b00) begin n_fail++; $display("FAIL reset_pix got d=%h s=%b want 00/00", pd1, ps1); end
        n_chk++; if (col1 !== 1'b0 || cv1 !== 1'b0) begin n_fail++; $display("FAIL reset_collide got %b/%b want 0/0", col1, cv1); end
        n_chk++; if (rom_addr1 !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", rom_addr1); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int px [6] = '{100, 212, 213, 0, 0, 0};
        int py [6] = '{50, 206, 50, 0, 0, 0};
        set_spr(0, 1, 0, 100, 50); set_spr(1, 0, 0, 0, 0);
        rom_mode = 0; rom_const[0] = 8'h1C; rom_const[1] = 8'h55;
        for (int i = 0; i < 6; i++) begin
            step(i < 3, px[i], py[i], 0);
            n_chk++; if (rom_addr1[AW-1:0] !== exp_a0[cyc]) begin n_fail++; $display("FAIL single_addr i=%0d got %0d want %0d", i, rom_addr1[AW-1:0], exp_a0[cyc]); end
            n_chk++; if (pv1 !== exp_pv[cyc] || pd1 !== exp_pd[cyc] || ps1 !== exp_ps[cyc]) begin n_fail++; $display("FAIL single_pix i=%0d got v=%b d=%h s=%b want v=%b d=%h s=%b", i, pv1, pd1, ps1, exp_pv[cyc], exp_pd[cyc], exp_ps[cyc]); end
        end
    endtask

    task automatic test_mirror;
        set_spr(0, 1, 1, 100, 50);
        step(1, 100, 50, 0);
        n_chk++; if (rom_addr1[AW-1:0] !== exp_a0[cyc]) begin n_fail++; $display("FAIL mirror_left got %0d want %0d", rom_addr1[AW-1:0], exp_a0[cyc]); end
        step(1, 212, 50, 0);
        n_chk++; if (rom_addr1[AW-1:0] !== exp_a0[cyc]) begin n_fail++; $display("FAIL mirror_right got %0d want %0d", rom_addr1[AW-1:0], exp_a0[cyc]); end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    endtask

    task automatic test_priority;
        logic [7:0] c0 [2] = '{8'hE3, 8'hFF};
        set_spr(0, 1, 0, 200, 200); set_spr(1, 1, 0, 200, 200);
        rom_const[1] = 8'h1C;
        for (int t = 0; t < 2; t++) begin
            rom_const[0] = c0[t];
            step(1, 210, 230, 0);
            for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
            n_chk++; if (pv1 !== exp_pv[cyc] || pd1 !== exp_pd[cyc] || ps1 !== exp_ps[cyc]) begin n_fail++; $display("FAIL priority t=%0d got d=%h s=%b want d=%h s=%b", t, pd1, ps1, exp_pd[cyc], exp_ps[cyc]); end
            for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        end
    endtask

    task automatic test_latency;
        int c0, lat1, lat2, cnt, first, last;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        c0 = cyc; lat1 = -1; lat2 = -1;
        step(1, 5, 5, 0);
        for (int i = 0; i < 8; i++) begin
            if (pv1 && lat1 < 0) lat1 = cyc - c0;
            if (pv2 && lat2 < 0) lat2 = cyc - c0;
            step(0, 0, 0, 0);
        end
        n_chk++; if (lat1 != 3) begin n_fail++; $display("FAIL latency_lat1 got %0d want 3", lat1); end
        n_chk++; if (lat2 != 4) begin n_fail++; $display("FAIL latency_lat2 got %0d want 4", lat2); end
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 13; i++) begin
            step(i < 8, 200 + i * 3, 205 + i, 0);
            if (pv1) begin cnt++; if (first < 0) first = cyc; last = cyc; end
            n_chk++; if (pv1 !== exp_pv[cyc] || pd1 !== exp_pd[cyc] || ps1 !== exp_ps[cyc]) begin n_fail++; $display("FAIL b2b_pix i=%0d got v=%b d=%h s=%b want v=%b d=%h s=%b", i, pv1, pd1, ps1, exp_pv[cyc], exp_pd[cyc], exp_ps[cyc]); end
        end
        n_chk++; if (cnt != 8 || last - first != 7) begin n_fail++; $display("FAIL b2b_gapless got count=%0d span=%0d want 8/7", cnt, last - first); end
    endtask

    task automatic test_edge;
        set_spr(0, 1, 0, 950, 0); set_spr(1, 0, 0, 0, 0);
        step(1, 10, 5, 0);
        n_chk++; if (rom_addr1[AW-1:0] !== exp_a0[cyc]) begin n_fail++; $display("FAIL edge_wrap_addr got %0d want %0d", rom_addr1[AW-1:0], exp_a0[cyc]); end
        step(1, 1000, 5, 0);
        n_chk++; if (rom_addr1[AW-1:0] !== exp_a0[cyc]) begin n_fail++; $display("FAIL edge_in_addr got %0d want %0d", rom_addr1[AW-1:0], exp_a0[cyc]); end
        step(0, 0, 0, 0);
        n_chk++; if (pv1 !== exp_pv[cyc] || pd1 !== exp_pd[cyc] || ps1 !== exp_ps[cyc]) begin n_fail++; $display("FAIL edge_wrap_pix got d=%h s=%b want d=%h s=%b", pd1, ps1, exp_pd[cyc], exp_ps[cyc]); end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    endtask

    task automatic test_collision;
        int px [14] = '{0, 412, 350, 450, 0, 0, 350, 500, 0, 5, 0, 0, 0, 0};
        int py [14] = '{0, 300, 310, 310, 0, 0, 300, 320, 0, 5, 0, 0, 0, 0};
        bit pv [14] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        bit pf [14] = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
        int pulses = 0;
        set_spr(0, 1, 0, 300, 300); set_spr(1, 1, 0, 412, 300);
        rom_mode = 0; rom_const[0] = 8'h1C; rom_const[1] = 8'h1C;
        for (int i = 0; i < 14; i++) begin
            step(pv[i], px[i], py[i], pf[i]);
            if (cv1) pulses++;
            n_chk++; if (col1 !== exp_col[cyc] || cv1 !== exp_cv[cyc]) begin n_fail++; $display("FAIL collide i=%0d got c=%b cv=%b want c=%b cv=%b", i, col1, cv1, exp_col[cyc], exp_cv[cyc]); end
        end
        n_chk++; if (pulses != 2) begin n_fail++; $display("FAIL collide_pulses got %0d want 2", pulses); end
    endtask

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
    endfunction

    task automatic test_random;
        int x, y, b;
        rom_mode = 1;
        for (int i = 0; i < 1200; i++) begin
            if (i % 100 == 0) begin
                set_spr(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
                set_spr(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        clampc(sx[0] + int'($urandom_range(0, 160)) - 80),
                        clampc(sy[0] + int'($urandom_range(0, 160)) - 80));
            end
            b = int'($urandom_range(0, 1));
            x = clampc(sx[b] + int'($urandom_range(0, 140)) - 15);
            y = clampc(sy[b] + int'($urandom_range(0, 180)) - 12);
            step($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 49) == 0);
            n_chk++; if (rom_addr1 !== {exp_a1[cyc], exp_a0[cyc]}) begin n_fail++; $display("FAIL rand_addr cyc=%0d got %h want %h", cyc, rom_addr1, {exp_a1[cyc], exp_a0[cyc]}); end
            n_chk++; if (pv1 !== exp_pv[cyc] || pd1 !== exp_pd[cyc] || ps1 !== exp_ps[cyc]) begin n_fail++; $display("FAIL rand_pix cyc=%0d got v=%b d=%h s=%b want v=%b d=%h s=%b", cyc, pv1, pd1, ps1, exp_pv[cyc], exp_pd[cyc], exp_ps[cyc]); end
            n_chk++; if (col1 !== exp_col[cyc] || cv1 !== exp_cv[cyc]) begin n_fail++; $display("FAIL rand_collide cyc=%0d got c=%b cv=%b want c=%b cv=%b", cyc, col1, cv1, exp_col[cyc], exp_cv[cyc]); end
            n_chk++; if (pv2 !== exp_pv[cyc-1] || pd2 !== exp_pd[cyc-1] || ps2 !== exp_ps[cyc-1] || cv2 !== exp_cv[cyc-1]) begin n_fail++; $display("FAIL rand_lat2 cyc=%0d got v=%b d=%h s=%b cv=%b want v=%b d=%h s=%b cv=%b", cyc, pv2, pd2, ps2, cv2, exp_pv[cyc-1], exp_pd[cyc-1], exp_ps[cyc-1], exp_cv[cyc-1]); end
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid;
        int px [12] = '{0, 0, 150, 150, 0, 0, 0, 0, 0, 0, 0, 0};
        int py [12] = '{0, 0, 150, 151, 0, 0, 0, 0, 0, 0, 0, 0};
        bit pv [12] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        bit pf [12] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        int pulses = 0;
        set_spr(0, 1, 0, 100, 100); set_spr(1, 1, 0, 100, 100);
        rom_mode = 0; rom_const[0] = 8'h1C; rom_const[1] = 8'h2A;
        step(1, 0, 0, 1);
        step(1, 150, 150, 0);
        step(1, 151, 150, 0);
        rst_n = 1'b0;
        #1;
        n_chk++; if (pv1 !== 1'b0 || col1 !== 1'b0 || pd1 !== 8'h00) begin n_fail++; $display("FAIL midreset_async got v=%b c=%b d=%h want 0/0/00", pv1, col1, pd1); end
        m_armed = 0; m_acc = 0; m_col = 0;
        clear_exp(cyc, cyc + 4);
        for (int i = 0; i < 12; i++) begin
            if (i == 2) rst_n = 1'b1;
            step(pv[i], px[i], py[i], pf[i]);
            if (cv1) pulses++;
            n_chk++; if (pv1 !== exp_pv[cyc] || col1 !== exp_col[cyc] || cv1 !== exp_cv[cyc]) begin n_fail++; $display("FAIL midreset i=%0d got v=%b c=%b cv=%b want v=%b c=%b cv=%b", i, pv1, col1, cv1, exp_pv[cyc], exp_col[cyc], exp_cv[cyc]); end
        end
        n_chk++; if (pulses != 2) begin n_fail++; $display("FAIL midreset_pulses got %0d want 2", pulses); end
    endtask

    initial begin
        clear_exp(0, DEPTH - 1);
        rom_mode = 0; rom_const[0] = 8'h00; rom_const[1] = 8'h00;
        spr_en_i = '0; spr_mirror_i = '0; spr_x_i = '0; spr_y_i = '0;
        set_spr(0, 0, 0, 0, 0); set_spr(1, 0, 0, 0, 0);
        m_armed = 0; m_acc = 0; m_col = 0;
        test_reset;
        test_single;
        test_mirror;
        test_priority;
        test_latency;
        test_edge;
        test_collision;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
